// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store bridge.
//   lsu_state_t : bridge FSM states
//   F3_*        : funct3 encodings for the supported access sizes
//   is_illegal  : request legality (bad operation or misalignment)
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // Only meaningful while rd or wr is high.
  function automatic logic is_illegal(input logic       rd,
                                      input logic       wr,
                                      input logic [2:0] f3,
                                      input logic [1:0] a);
    logic bad_op;
    logic misaligned;
    if (rd && wr) begin
      bad_op = 1'b1;
    end else if (wr) begin
      bad_op = (f3 > F3_W);
    end else begin
      bad_op = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    end
    case (f3)
      F3_H, F3_HU: misaligned = a[0];
      F3_W:        misaligned = (a != 2'b00);
      default:     misaligned = 1'b0;
    endcase
    return bad_op || misaligned;
  endfunction

endpackage

// File: rtl/lsu_load_format.sv
// Load result formatting: picks the byte/halfword addressed by the low
// address bits out of the bus word and sign- or zero-extends it.
//   funct3 : latched access size/sign
//   a      : latched address bits [1:0]
//   word   : raw read word from the bus
//   result : formatted 32-bit load value
module lsu_load_format
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  a,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  always_comb begin
    case (a)
      2'd0:    sel_b = word[7:0];
      2'd1:    sel_b = word[15:8];
      2'd2:    sel_b = word[23:16];
      default: sel_b = word[31:24];
    endcase
    // Halfwords are always 2-byte aligned here, so a[1] picks the half.
    sel_h = a[1] ? word[31:16] : word[15:0];

    case (funct3)
      F3_B:    result = {{24{sel_b[7]}}, sel_b};
      F3_BU:   result = {24'd0, sel_b};
      F3_H:    result = {{16{sel_h[15]}}, sel_h};
      F3_HU:   result = {16'd0, sel_h};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/lsu_mem_bridge.sv
// Load/store bridge between the single-cycle datapath memory port and a
// valid/ready data-memory bus. Formats store data/strobes, formats load
// results, stalls the core until the access completes, and faults on
// illegal, misaligned or timed-out accesses without touching the bus.
//
// Ports
//   clk, reset_n              : clock, asynchronous active-low reset
//   core_rd/core_wr           : load / store request from the datapath
//   core_funct3, core_addr    : access size/sign and byte address
//   core_wdata                : raw rs2 store data
//   core_stall                : hold PC/regfile while high
//   core_rdata, core_fault    : load result and fault flag, valid in DONE
//   mem_req_valid/ready       : bus request handshake
//   mem_we, mem_addr          : write flag, word-aligned address
//   mem_wstrb, mem_wdata      : byte enables, lane-replicated store data
//   mem_rsp_valid, mem_rdata  : read data / write acknowledge
//   dbg_state                 : current FSM state for observation
//
// Handshake: a request transfers on a rising edge where mem_req_valid and
// mem_req_ready are both high; once raised, mem_req_valid and the request
// fields stay stable until that edge. A response is a single-cycle
// mem_rsp_valid pulse, and may coincide with the accepting edge.
module lsu_mem_bridge
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        core_rd,
  input  logic        core_wr,
  input  logic [2:0]  core_funct3,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic        core_stall,
  output logic [31:0] core_rdata,
  output logic        core_fault,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata,
  output lsu_state_t  dbg_state
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYCLES - 1);

  lsu_state_t    state;
  logic [CW-1:0] cnt;
  logic [2:0]    lat_f3;
  logic [1:0]    lat_a;
  logic [31:0]   st_data;
  logic [3:0]    st_strb;
  logic [31:0]   load_result;
  logic          illegal;

  assign dbg_state = state;

  // Gated by reset_n so the stall drops the moment reset is asserted.
  assign core_stall = reset_n & (core_rd | core_wr) & (state != DONE);

  assign illegal = is_illegal(core_rd, core_wr, core_funct3, core_addr[1:0]);

  // Store lane replication and byte enables from the live request.
  always_comb begin
    st_data = core_wdata;
    st_strb = 4'b1111;
    case (core_funct3)
      F3_B: begin
        st_data = {4{core_wdata[7:0]}};
        st_strb = 4'b0001 << core_addr[1:0];
      end
      F3_H: begin
        st_data = {2{core_wdata[15:0]}};
        st_strb = 4'b0011 << core_addr[1:0];
      end
      default: ;
    endcase
  end

  lsu_load_format u_load_format (
    .funct3 (lat_f3),
    .a      (lat_a),
    .word   (mem_rdata),
    .result (load_result)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      lat_f3        <= '0;
      lat_a         <= '0;
      core_rdata    <= '0;
      core_fault    <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wstrb     <= '0;
      mem_wdata     <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Stray responses are ignored here; only new requests matter.
          if (core_rd || core_wr) begin
            lat_f3 <= core_funct3;
            lat_a  <= core_addr[1:0];
            cnt    <= '0;
            if (illegal) begin
              core_fault <= 1'b1;
              state      <= DONE;
            end else begin
              mem_req_valid <= 1'b1;
              mem_we        <= core_wr;
              mem_addr      <= {core_addr[31:2], 2'b00};
              mem_wstrb     <= core_wr ? st_strb : 4'b0000;
              mem_wdata     <= core_wr ? st_data : 32'd0;
              state         <= REQ;
            end
          end
        end

        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            if (mem_rsp_valid) begin
              // Write acknowledges carry no data; keep the last load value.
              if (!mem_we) core_rdata <= load_result;
              state <= DONE;
            end else begin
              state <= WAIT_RSP;
            end
          end
        end

        WAIT_RSP: begin
          if (mem_rsp_valid) begin
            if (!mem_we) core_rdata <= load_result;
            state <= DONE;
          end else if (cnt == LAST_CNT) begin
            core_fault <= 1'b1;
            core_rdata <= '0;
            state      <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        DONE: begin
          // The core retires on this edge; the next request is seen in IDLE.
          core_fault <= 1'b0;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Directed testbench for lsu_mem_bridge. Each access pushes its expected
// bus request and expected completion into queues; two monitors pop and
// compare when the DUT presents an accepted request or reaches DONE.
module tb_lsu_mem_bridge;
  import lsu_pkg::*;

  localparam int unsigned T_CYC = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        core_rd, core_wr;
  logic [2:0]  core_funct3;
  logic [31:0] core_addr, core_wdata;
  logic        core_stall;
  logic [31:0] core_rdata;
  logic        core_fault;
  logic        mem_req_valid, mem_req_ready, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;
  lsu_state_t  dbg_state;

  int checks = 0;
  int errors = 0;
  int stall_cnt = 0;

  logic [33:0] exp_q[$];  // {check_rdata, fault, rdata}
  logic [68:0] bus_q[$];  // {we, addr, wstrb, wdata}
  logic [33:0] done_e;
  logic [68:0] bus_e;

  lsu_mem_bridge #(.TIMEOUT_CYCLES(T_CYC)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .core_rd       (core_rd),
    .core_wr       (core_wr),
    .core_funct3   (core_funct3),
    .core_addr     (core_addr),
    .core_wdata    (core_wdata),
    .core_stall    (core_stall),
    .core_rdata    (core_rdata),
    .core_fault    (core_fault),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wstrb     (mem_wstrb),
    .mem_wdata     (mem_wdata),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rdata     (mem_rdata),
    .dbg_state     (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: completion monitor
  always @(negedge clk) begin
    if (reset_n && dbg_state == DONE) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: got DONE with nothing pending, expected no DONE");
      end else begin
        done_e = exp_q.pop_front();
        check("core_fault", 64'(core_fault), 64'(done_e[32]));
        if (done_e[33]) check("core_rdata", 64'(core_rdata), 64'(done_e[31:0]));
        check("stall_in_done", 64'(core_stall), 64'd0);
      end
    end
  end

  // Scoreboard: bus request monitor (sampled late in the cycle)
  always begin
    @(negedge clk);
    #3;
    if (mem_req_valid) begin
      checks++;
      if (bus_q.size() == 0) begin
        errors++;
        $display("FAIL bus_unexpected: got mem_req_valid=1 addr 0x%0h, expected no request", mem_addr);
      end else if (mem_req_ready) begin
        bus_e = bus_q.pop_front();
        check("mem_we", 64'(mem_we), 64'(bus_e[68]));
        check("mem_addr", 64'(mem_addr), 64'(bus_e[67:36]));
        check("mem_wstrb", 64'(mem_wstrb), 64'(bus_e[35:32]));
        if (bus_e[68]) check("mem_wdata", 64'(mem_wdata), 64'(bus_e[31:0]));
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(negedge clk);
    if (core_stall) stall_cnt++;
  endtask

  // Called at a falling edge with the core request already driven.
  task automatic finish_access(input bit legal, input int ready_wait, input int rsp_wait,
                               input bit no_rsp, input logic [31:0] word, input int exp_stall);
    int n;
    stall_cnt = 0;
    #1;
    if (core_stall) stall_cnt++;
    if (legal) begin
      n = 0;
      while (!mem_req_valid && n < 20) begin tick(); n++; end
      if (!mem_req_valid) begin
        checks++; errors++;
        $display("FAIL req_wait: got no mem_req_valid in 20 cycles, expected a request");
      end
      repeat (ready_wait) tick();
      mem_req_ready = 1'b1;
      mem_rdata     = word;
      if (rsp_wait == 0) mem_rsp_valid = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      if (rsp_wait > 0 && !no_rsp) begin
        repeat (rsp_wait - 1) tick();
        mem_rsp_valid = 1'b1;
        tick();
        mem_rsp_valid = 1'b0;
      end
    end
    n = 0;
    while (dbg_state != DONE && n < 50) begin tick(); n++; end
    if (dbg_state != DONE) begin
      checks++; errors++;
      $display("FAIL done_wait: got state %0d after 50 cycles, expected DONE", dbg_state);
    end
    check("stall_cycles", 64'(stall_cnt), 64'(exp_stall));
    core_rd = 1'b0;
    core_wr = 1'b0;
    tick();
  endtask

  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input bit legal, input int ready_wait, input int rsp_wait,
                        input bit no_rsp, input logic [31:0] word,
                        input bit chk_rd, input logic [31:0] exp_rdata, input bit exp_fault,
                        input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                        input int exp_stall);
    core_rd     = rd;
    core_wr     = wr;
    core_funct3 = f3;
    core_addr   = addr;
    core_wdata  = wdata;
    exp_q.push_back({chk_rd, exp_fault, exp_rdata});
    if (legal) bus_q.push_back({wr, addr[31:2], 2'b00, exp_strb, exp_wdata});
    finish_access(legal, ready_wait, rsp_wait, no_rsp, word, exp_stall);
  endtask

  // Stimulus
  initial begin
    reset_n       = 1'b0;
    core_rd       = 1'b0;
    core_wr       = 1'b0;
    core_funct3   = 3'd0;
    core_addr     = 32'd0;
    core_wdata    = 32'd0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rdata     = 32'd0;
    repeat (2) @(negedge clk);
    check("reset_state", 64'(dbg_state), 64'(IDLE));
    check("reset_outputs", {26'd0, core_stall, core_fault, mem_req_valid, mem_we, mem_wstrb, core_rdata},
          64'd0);
    check("reset_mem_addr", 64'(mem_addr), 64'd0);
    reset_n = 1'b1;
    tick();

    //     rd wr f3     addr        wdata         lg rw rs nr word          cr exp_rdata     flt strb     exp_wdata     stall
    access(0, 1, F3_W,  32'h104, 32'hDEADBEEF, 1, 0, 1, 0, 32'h0,        0, 32'h0,        0, 4'b1111, 32'hDEADBEEF, 3);
    access(0, 1, F3_B,  32'h203, 32'h000000A5, 1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 4'b1000, 32'hA5A5A5A5, 2);
    access(1, 0, F3_B,  32'h301, 32'h0,        1, 1, 2, 0, 32'h123480FF, 1, 32'hFFFFFF80, 0, 4'b0000, 32'h0,        5);
    access(1, 0, F3_BU, 32'h301, 32'h0,        1, 0, 1, 0, 32'h123480FF, 1, 32'h00000080, 0, 4'b0000, 32'h0,        3);
    access(1, 0, F3_H,  32'h302, 32'h0,        1, 0, 0, 0, 32'h123480FF, 1, 32'h00001234, 0, 4'b0000, 32'h0,        2);
    access(1, 0, F3_H,  32'h300, 32'h0,        1, 0, 1, 0, 32'hABCD8001, 1, 32'hFFFF8001, 0, 4'b0000, 32'h0,        3);
    access(1, 0, F3_HU, 32'h300, 32'h0,        1, 0, 1, 0, 32'hABCD8001, 1, 32'h00008001, 0, 4'b0000, 32'h0,        3);
    access(1, 0, F3_W,  32'h100, 32'h0,        1, 2, 3, 0, 32'hCAFEF00D, 1, 32'hCAFEF00D, 0, 4'b0000, 32'h0,        7);
    access(0, 1, F3_H,  32'h102, 32'h1234BEEF, 1, 0, 1, 0, 32'h0,        0, 32'h0,        0, 4'b1100, 32'hBEEFBEEF, 3);
    // Illegal requests: fault in DONE after a single stalled IDLE cycle.
    access(1, 0, F3_W,  32'h102, 32'h0,        0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 4'b0000, 32'h0,        1);
    access(1, 1, F3_W,  32'h100, 32'h0,        0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 4'b0000, 32'h0,        1);
    access(1, 0, 3'd3,  32'h100, 32'h0,        0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 4'b0000, 32'h0,        1);
    access(0, 1, 3'd4,  32'h100, 32'h0,        0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 4'b0000, 32'h0,        1);
    access(0, 1, F3_H,  32'h101, 32'h0,        0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 4'b0000, 32'h0,        1);
    access(1, 0, F3_HU, 32'h303, 32'h0,        0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 4'b0000, 32'h0,        1);
    // Fault must not stick to the following legal access.
    access(1, 0, F3_B,  32'h300, 32'h0,        1, 0, 1, 0, 32'h000000FF, 1, 32'hFFFFFFFF, 0, 4'b0000, 32'h0,        3);
    // Timeout: 4 WAIT_RSP cycles, then fault with zero data.
    access(1, 0, F3_W,  32'h200, 32'h0,        1, 0, 1, 1, 32'h0,        1, 32'h00000000, 1, 4'b0000, 32'h0,        6);

    // Late response while idle is ignored.
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'h55555555;
    tick();
    mem_rsp_valid = 1'b0;
    check("late_rsp_state", 64'(dbg_state), 64'(IDLE));
    check("late_rsp_rdata", 64'(core_rdata), 64'd0);
    check("late_rsp_fault", 64'(core_fault), 64'd0);

    // Reset during REQ with the bus not ready, then the same load reissues.
    core_rd     = 1'b1;
    core_wr     = 1'b0;
    core_funct3 = F3_B;
    core_addr   = 32'h301;
    core_wdata  = 32'h0;
    exp_q.push_back({1'b1, 1'b0, 32'hFFFFFF80});
    bus_q.push_back({1'b0, 32'h300, 4'b0000, 32'h0});
    tick();
    check("rst_pre_valid", 64'(mem_req_valid), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_valid_drop", 64'(mem_req_valid), 64'd0);
    check("rst_stall_drop", 64'(core_stall), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    @(negedge clk);
    reset_n = 1'b1;
    finish_access(1, 0, 1, 0, 32'h123480FF, 3);

    access(1, 0, F3_W,  32'h104, 32'h0,        1, 1, 1, 0, 32'h0BADF00D, 1, 32'h0BADF00D, 0, 4'b0000, 32'h0,        4);

    repeat (3) tick();
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("bus_q_drained", 64'(bus_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    checks++;
    errors++;
    $display("FAIL watchdog: got no completion by 200000 time units, expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
